// File: rtl/ra_pkg.sv
// Shared definitions for the register-array micro-sequencer: op codes, FSM states
// and the bit layout of the 12-bit strobe vector.
package ra_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_LOAD  = 3'd1,
      OP_STORE = 3'd2,
      OP_MOV   = 3'd3,
      OP_MUL   = 3'd4,
      OP_DIV   = 3'd5,
      OP_SAVEF = 3'd6,
      OP_RESTF = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PH1  = 2'd1,
      PH2  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Strobe vector layout: {IDIV, IMUL, EF, IF, E[3:0], I[3:0]}
   localparam int STRB_W     = 12;
   localparam int STRB_I_LSB = 0;
   localparam int STRB_E_LSB = 4;
   localparam int STRB_IF    = 8;
   localparam int STRB_EF    = 9;
   localparam int STRB_IMUL  = 10;
   localparam int STRB_IDIV  = 11;

   // Number of strobe phases a command expands into (0, 1 or 2).
   function automatic logic [1:0] op_phases(op_t op, logic [1:0] src, logic [1:0] dst);
      logic [1:0] n;
      case (op)
         OP_NOP:  n = 2'd0;
         OP_MOV:  n = (src == dst) ? 2'd0 : 2'd2;
         default: n = 2'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ra_ctrl_if.sv
// Command channel from instruction decode into the register-array sequencer.
interface ra_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [1:0] cmd_src;
   logic [1:0] cmd_dst;

   modport master (
      output cmd_valid, cmd_op, cmd_src, cmd_dst,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_src, cmd_dst,
      output cmd_ready
   );
endinterface

// File: rtl/ra_strobe_dec.sv
// Combinational map of (op, phase, src, dst) onto the 12-bit strobe vector.
// phase=0 selects the first strobe phase, phase=1 the second (MOV only).
module ra_strobe_dec
   import ra_pkg::*;
(
   input  op_t               op,
   input  logic              phase,
   input  logic [1:0]        src,
   input  logic [1:0]        dst,
   output logic [STRB_W-1:0] strb
);

   logic [3:0] src_oh;
   logic [3:0] dst_oh;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_onehot
         assign src_oh[gi] = (src == 2'(gi));
         assign dst_oh[gi] = (dst == 2'(gi));
      end
   endgenerate

   always_comb begin
      strb = '0;
      case (op)
         OP_LOAD:  strb[STRB_I_LSB +: 4] = dst_oh;
         OP_STORE: strb[STRB_E_LSB +: 4] = src_oh;
         OP_MOV: begin
            // Read the source out first, then write it into the destination.
            if (phase) strb[STRB_I_LSB +: 4] = dst_oh;
            else       strb[STRB_E_LSB +: 4] = src_oh;
         end
         OP_MUL:   strb[STRB_IMUL] = 1'b1;
         OP_DIV:   strb[STRB_IDIV] = 1'b1;
         OP_SAVEF: strb[STRB_IF]   = 1'b1;
         OP_RESTF: strb[STRB_EF]   = 1'b1;
         default:  strb = '0;
      endcase
   end

endmodule

// File: rtl/ra_ctrl.sv
// Register-array micro-sequencer: accepts one command per handshake and plays it
// out as one or two timed strobe phases, with all outputs registered.
module ra_ctrl
   import ra_pkg::*;
#(
   parameter int STROBE_CYCLES = 1
)
(
   input  logic       clk,
   input  logic       rst,
   ra_ctrl_if.slave   cmd,
   output logic [3:0] I,
   output logic [3:0] E,
   output logic       IF,
   output logic       EF,
   output logic       IMUL,
   output logic       IDIV,
   output logic       busy,
   output logic       done
);

   localparam int            CW       = $clog2(STROBE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(STROBE_CYCLES - 1);

   state_t            state_reg;
   logic [CW-1:0]     cnt_reg;
   op_t               op_reg;
   logic [1:0]        src_reg;
   logic [1:0]        dst_reg;
   logic              two_phase_reg;
   logic [STRB_W-1:0] strobe_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              ready_reg;

   logic              accept;
   logic              in_phase;
   logic [1:0]        new_phases;
   op_t               dec_op;
   logic [1:0]        dec_src;
   logic [1:0]        dec_dst;
   logic              dec_phase;
   logic [STRB_W-1:0] dec_strb;

   assign accept     = cmd.cmd_valid && ready_reg;
   assign in_phase   = (state_reg == PH1) || (state_reg == PH2);
   assign new_phases = op_phases(op_t'(cmd.cmd_op), cmd.cmd_src, cmd.cmd_dst);

   // While idle the decoder looks at the incoming command so its first strobe
   // can be registered on the accept edge; during a phase it looks at the latch.
   assign dec_op    = in_phase ? op_reg  : op_t'(cmd.cmd_op);
   assign dec_src   = in_phase ? src_reg : cmd.cmd_src;
   assign dec_dst   = in_phase ? dst_reg : cmd.cmd_dst;
   assign dec_phase = (state_reg == PH1);

   ra_strobe_dec u_dec (
      .op    (dec_op),
      .phase (dec_phase),
      .src   (dec_src),
      .dst   (dec_dst),
      .strb  (dec_strb)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         op_reg        <= OP_NOP;
         src_reg       <= '0;
         dst_reg       <= '0;
         two_phase_reg <= 1'b0;
         strobe_reg    <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         ready_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               if (accept) begin
                  op_reg        <= op_t'(cmd.cmd_op);
                  src_reg       <= cmd.cmd_src;
                  dst_reg       <= cmd.cmd_dst;
                  two_phase_reg <= (new_phases == 2'd2);
                  if (new_phases == 2'd0) begin
                     state_reg  <= DONE;
                     done_reg   <= 1'b1;
                     ready_reg  <= 1'b1;
                     strobe_reg <= '0;
                     busy_reg   <= 1'b0;
                  end else begin
                     state_reg  <= PH1;
                     cnt_reg    <= CNT_LOAD;
                     strobe_reg <= dec_strb;
                     busy_reg   <= 1'b1;
                     ready_reg  <= 1'b0;
                  end
               end else begin
                  state_reg  <= IDLE;
                  ready_reg  <= 1'b1;
                  strobe_reg <= '0;
                  busy_reg   <= 1'b0;
               end
            end

            PH1: begin
               if (cnt_reg == '0) begin
                  if (two_phase_reg) begin
                     // Swap strobes on the same edge: no gap, no overlap.
                     state_reg  <= PH2;
                     cnt_reg    <= CNT_LOAD;
                     strobe_reg <= dec_strb;
                  end else begin
                     state_reg  <= DONE;
                     done_reg   <= 1'b1;
                     ready_reg  <= 1'b1;
                     strobe_reg <= '0;
                     busy_reg   <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg - CW'(1);
               end
            end

            PH2: begin
               if (cnt_reg == '0) begin
                  state_reg  <= DONE;
                  done_reg   <= 1'b1;
                  ready_reg  <= 1'b1;
                  strobe_reg <= '0;
                  busy_reg   <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg - CW'(1);
               end
            end

            default: begin
               state_reg  <= IDLE;
               strobe_reg <= '0;
               busy_reg   <= 1'b0;
               ready_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd.cmd_ready = ready_reg;
   assign I    = strobe_reg[STRB_I_LSB +: 4];
   assign E    = strobe_reg[STRB_E_LSB +: 4];
   assign IF   = strobe_reg[STRB_IF];
   assign EF   = strobe_reg[STRB_EF];
   assign IMUL = strobe_reg[STRB_IMUL];
   assign IDIV = strobe_reg[STRB_IDIV];
   assign busy = busy_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_ra_ctrl.sv
// Bench for ra_ctrl: two instances (STROBE_CYCLES 1 and 3) share one stimulus stream
// and are each compared cycle by cycle against a per-command timeline model.
module tb_ra_ctrl;
   import ra_pkg::*;

   typedef struct packed {
      logic [11:0] strb;
      logic        busy;
      logic        done;
      logic        ready;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ra_ctrl_if bus_a ();
   ra_ctrl_if bus_b ();

   logic [3:0] a_i, a_e, b_i, b_e;
   logic       a_if, a_ef, a_imul, a_idiv, a_busy, a_done;
   logic       b_if, b_ef, b_imul, b_idiv, b_busy, b_done;

   ra_ctrl #(.STROBE_CYCLES(1)) dut_a (
      .clk (clk), .rst (rst), .cmd (bus_a),
      .I (a_i), .E (a_e), .IF (a_if), .EF (a_ef), .IMUL (a_imul), .IDIV (a_idiv),
      .busy (a_busy), .done (a_done)
   );

   ra_ctrl #(.STROBE_CYCLES(3)) dut_b (
      .clk (clk), .rst (rst), .cmd (bus_b),
      .I (b_i), .E (b_e), .IF (b_if), .EF (b_ef), .IMUL (b_imul), .IDIV (b_idiv),
      .busy (b_busy), .done (b_done)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   end_cyc [2] = '{-1, -1};
   bit   rdy_ok [2];
   exp_t sched [2][64];

   function automatic exp_t observe(input int d);
      exp_t o;
      if (d == 0) begin
         o.strb  = {a_idiv, a_imul, a_ef, a_if, a_e, a_i};
         o.busy  = a_busy;
         o.done  = a_done;
         o.ready = bus_a.cmd_ready;
      end else begin
         o.strb  = {b_idiv, b_imul, b_ef, b_if, b_e, b_i};
         o.busy  = b_busy;
         o.done  = b_done;
         o.ready = bus_b.cmd_ready;
      end
      return o;
   endfunction

   // Expected outputs this cycle: a scheduled command cycle, else quiet idle.
   function automatic exp_t expect_now(input int d);
      exp_t x;
      if (cyc <= end_cyc[d]) begin
         x = sched[d][cyc % 64];
      end else begin
         x.strb  = '0;
         x.busy  = 1'b0;
         x.done  = 1'b0;
         x.ready = rdy_ok[d];
      end
      return x;
   endfunction

   task automatic chk(input string tag, input int d, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d cyc%0d observed=%h expected=%h", tag, d, cyc, obs, exp);
      end
   endtask

   task automatic check_now();
      for (int d = 0; d < 2; d++) begin
         exp_t o;
         exp_t x;
         o = observe(d);
         x = expect_now(d);
         chk("strobes", d, o.strb, x.strb);
         chk("busy",    d, {11'b0, o.busy},  {11'b0, x.busy});
         chk("done",    d, {11'b0, o.done},  {11'b0, x.done});
         chk("ready",   d, {11'b0, o.ready}, {11'b0, x.ready});
         chk("one_strobe_max", d, 12'($countones(o.strb) <= 1), 12'd1);
      end
   endtask

   task automatic zero_check(input string tag);
      for (int d = 0; d < 2; d++) begin
         exp_t o;
         o = observe(d);
         chk(tag, d, {o.strb}, 12'd0);
         chk(tag, d, {9'b0, o.busy, o.done, o.ready}, 12'd0);
      end
   endtask

   // Append the timeline of an accepted command, starting next cycle.
   task automatic schedule(input int d, input op_t op, input logic [1:0] src, input logic [1:0] dst);
      int          sc;
      int          n;
      int          t;
      logic [11:0] ph [2];
      exp_t        rec;
      sc    = (d == 0) ? 1 : 3;
      ph[0] = '0;
      ph[1] = '0;
      case (op)
         OP_NOP:   n = 0;
         OP_LOAD:  begin n = 1; ph[0] = 12'd1 << dst; end
         OP_STORE: begin n = 1; ph[0] = 12'd16 << src; end
         OP_MOV:   begin
            n = (src == dst) ? 0 : 2;
            ph[0] = 12'd16 << src;
            ph[1] = 12'd1 << dst;
         end
         OP_MUL:   begin n = 1; ph[0] = 12'h400; end
         OP_DIV:   begin n = 1; ph[0] = 12'h800; end
         OP_SAVEF: begin n = 1; ph[0] = 12'h100; end
         default:  begin n = 1; ph[0] = 12'h200; end
      endcase
      t = cyc + 1;
      for (int p = 0; p < n; p++) begin
         for (int k = 0; k < sc; k++) begin
            rec.strb  = ph[p];
            rec.busy  = 1'b1;
            rec.done  = 1'b0;
            rec.ready = 1'b0;
            sched[d][t % 64] = rec;
            t++;
         end
      end
      rec.strb  = '0;
      rec.busy  = 1'b0;
      rec.done  = 1'b1;
      rec.ready = 1'b1;
      sched[d][t % 64] = rec;
      end_cyc[d] = t;
   endtask

   // Check this cycle, drive the inputs for the coming edge, advance one cycle.
   task automatic step(input bit v, input op_t op, input logic [1:0] src, input logic [1:0] dst);
      check_now();
      bus_a.cmd_valid = v; bus_a.cmd_op = op; bus_a.cmd_src = src; bus_a.cmd_dst = dst;
      bus_b.cmd_valid = v; bus_b.cmd_op = op; bus_b.cmd_src = src; bus_b.cmd_dst = dst;
      for (int d = 0; d < 2; d++) begin
         exp_t cur;
         cur = expect_now(d);
         if (v && cur.ready) schedule(d, op, src, dst);
      end
      rdy_ok = '{1'b1, 1'b1};
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, OP_NOP, 2'd0, 2'd0);
   endtask

   task automatic mid_reset();
      check_now();
      bus_a.cmd_valid = 1'b0;
      bus_b.cmd_valid = 1'b0;
      #2 rst = 1'b0;
      #1 zero_check("async_reset");
      @(negedge clk) zero_check("reset_hold");
      @(negedge clk) zero_check("reset_hold");
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         end_cyc[d] = cyc - 1;
         rdy_ok[d]  = 1'b0;
      end
   endtask

   initial begin
      bus_a.cmd_valid = 1'b0; bus_a.cmd_op = '0; bus_a.cmd_src = '0; bus_a.cmd_dst = '0;
      bus_b.cmd_valid = 1'b0; bus_b.cmd_op = '0; bus_b.cmd_src = '0; bus_b.cmd_dst = '0;
      rdy_ok = '{1'b0, 1'b0};

      @(negedge clk);
      zero_check("reset_state");
      rst = 1'b1;

      // ready stays low until the first edge after release
      step(1'b1, OP_LOAD, 2'd0, 2'd2);
      step(1'b1, OP_LOAD, 2'd0, 2'd2);
      step(1'b0, OP_NOP, 2'd0, 2'd0);
      idle(6);

      step(1'b1, OP_MOV, 2'd1, 2'd3);
      idle(9);

      step(1'b1, OP_MUL, 2'd0, 2'd0);
      idle(6);

      // back-to-back SAVEF then RESTF with valid held
      step(1'b1, OP_SAVEF, 2'd0, 2'd0);
      for (int k = 0; k < 4; k++) step(1'b1, OP_RESTF, 2'd0, 2'd0);
      idle(10);

      step(1'b1, OP_MOV, 2'd2, 2'd2);
      step(1'b1, OP_NOP, 2'd1, 2'd0);
      idle(4);

      // reset during PH2 of a MOV on the single-cycle instance
      step(1'b1, OP_MOV, 2'd1, 2'd3);
      step(1'b0, OP_NOP, 2'd0, 2'd0);
      mid_reset();
      idle(3);

      for (int k = 0; k < 300; k++) begin
         step($urandom_range(0, 9) < 7, op_t'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
